mem_arb: RTL and testbench
==========================

// Module: mem_arb
// PURPOSE
// Arbitrates the core's instruction-memory and data-memory request ports onto one
// single-ported memory bus. Sits directly downstream of the cpu block's im_*/dm_* ports.
// Each requester holds *_req_valid until it sees a one-cycle *_resp_valid pulse.
// Supports one outstanding bus transaction at a time.
// PARAMETERS
// AW        64  address width (im/dm/mem addr)
// DW        64  data width (wdata/rdata)
// DATA_PRIO 1   1: dm always wins over im; 0: round-robin, last-granted loses ties
// PORTS
// clk             in   1   clock, rising edge
// rst             in   1   asynchronous, active-low reset
// im_req_addr     in   AW  instruction fetch address
// im_req_valid    in   1   instruction request, held until im_resp_valid
// im_resp_rdata   out  DW  fetched data, valid with im_resp_valid
// im_resp_valid   out  1   one-cycle response pulse to instruction port
// dm_req_addr     in   AW  data address
// dm_req_wdata    in   DW  store data
// dm_req_wen      in   1   1 = store, 0 = load
// dm_req_valid    in   1   data request, held until dm_resp_valid
// dm_resp_rdata   out  DW  load data, valid with dm_resp_valid
// dm_resp_valid   out  1   one-cycle response pulse to data port
// mem_req_addr    out  AW  bus address (registered)
// mem_req_wdata   out  DW  bus write data (registered)
// mem_req_wen     out  1   bus write enable (registered)
// mem_req_valid   out  1   bus request valid; held until mem_req_ready
// mem_req_ready   in   1   bus accepts request when valid&ready
// mem_resp_rdata  in   DW  bus read data
// mem_resp_valid  in   1   bus response, one per accepted request (stores too)
// BEHAVIOUR
// - Reset (rst=0): state IDLE; all outputs 0; rr pointer = im; abort flag = 0.
// - FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, grant per DATA_PRIO, latch addr/wdata/wen (im: wen=0, wdata=0)
//         and grant id into regs, go REQ. mem_req_valid=1 from the next cycle.
//   REQ:  mem_req_valid=1, payload stable; on mem_req_ready go WAIT.
//   WAIT: on mem_resp_valid latch rdata, go RESP. Also sampled in the cycle after
//         acceptance. mem_resp_valid outside WAIT is ignored.
//   RESP: pulse granted port's resp_valid for exactly one cycle, with latched rdata; go IDLE.
// - Non-granted port's resp_valid stays 0. Its rdata output is don't-care.
// - Min latency (ready=1, mem responds the cycle after accept): request seen at cycle 0,
//   resp_valid at cycle 3.
// - Abort (flush): in REQ or WAIT, if the granted requester drops req_valid or changes
//   req_addr, set abort. The bus transaction still completes (mem_req_valid never
//   retracted). In RESP, suppress resp_valid. Clear abort on entry to IDLE.
// - No re-issue hazard: requests are sampled only in IDLE, never in RESP, so a
//   requester updating its address in the RESP cycle is seen fresh.
// - Round-robin (DATA_PRIO=0): both valid in IDLE -> grant the port not granted last.
//   Pointer updates on every grant.
// - Simultaneous arrival of both requests under DATA_PRIO=1 -> dm first, im next IDLE.
// - Async reset mid-transaction: FSM to IDLE and outputs to 0 immediately. Any later
//   bus response is ignored (not in WAIT).
// - Widths: no arithmetic; addr/data pass through unmodified.
// STRUCTURE
// - defines.vh: MA_IDLE/MA_REQ/MA_WAIT/MA_RESP 2-bit state encodings;
//   MA_GNT_IM/MA_GNT_DM grant ids.
// - Sub-module arb2 (2-way fixed/round-robin grant, combinational + 1-bit pointer reg).
//   Everything else stays inline.
// TESTING
// 1 Reset: rst low mid-REQ -> mem_req_valid, both resp_valid = 0 that cycle; state IDLE after release.
// 2 im only, addr 0x1000, ready=1, mem rdata 0x13 next cycle -> im_resp_valid pulse at cycle 3,
//   im_resp_rdata=0x13, dm_resp_valid=0.
// 3 Both valid same cycle, DATA_PRIO=1, dm store 0x2000/0xDEAD -> bus sees wen=1 @0x2000 first,
//   then im read; dm_resp first.
// 4 DATA_PRIO=0, both held valid continuously -> grants alternate im,dm,im,dm over 4 transactions.
// 5 ready held low 5 cycles -> mem_req_valid and payload stable all 5 cycles; accept on cycle 6.
// 6 im granted, im_req_valid drops in WAIT (flush), then re-raised @0x3000 -> stale response
//   dropped, no im_resp_valid; new request issued @0x3000 and returned normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the FSM state encoding and the grant ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_REQ  = 2'd1,
        MA_WAIT = 2'd2,
        MA_RESP = 2'd3
    } ma_state_e;

    typedef enum logic {
        MA_GNT_IM = 1'b0,
        MA_GNT_DM = 1'b1
    } ma_gnt_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the im/dm requester ports and the single memory bus.
// slave: arbiter view; master: core + memory environment view.
interface mem_arb_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic [AW-1:0] im_req_addr;
    logic          im_req_valid;
    logic [DW-1:0] im_resp_rdata;
    logic          im_resp_valid;

    logic [AW-1:0] dm_req_addr;
    logic [DW-1:0] dm_req_wdata;
    logic          dm_req_wen;
    logic          dm_req_valid;
    logic [DW-1:0] dm_resp_rdata;
    logic          dm_resp_valid;

    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_req_wen;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [DW-1:0] mem_resp_rdata;
    logic          mem_resp_valid;

    modport slave (
        input  im_req_addr, im_req_valid,
        output im_resp_rdata, im_resp_valid,
        input  dm_req_addr, dm_req_wdata, dm_req_wen, dm_req_valid,
        output dm_resp_rdata, dm_resp_valid,
        output mem_req_addr, mem_req_wdata, mem_req_wen, mem_req_valid,
        input  mem_req_ready, mem_resp_rdata, mem_resp_valid
    );

    modport master (
        output im_req_addr, im_req_valid,
        input  im_resp_rdata, im_resp_valid,
        output dm_req_addr, dm_req_wdata, dm_req_wen, dm_req_valid,
        input  dm_resp_rdata, dm_resp_valid,
        input  mem_req_addr, mem_req_wdata, mem_req_wen, mem_req_valid,
        output mem_req_ready, mem_resp_rdata, mem_resp_valid
    );

endinterface

// File: rtl/mem_arb_arb2.sv
// Two-way grant: fixed dm priority or round-robin with a 1-bit pointer.
// Ports: clk, rst (async active-low), req_im_i, req_dm_i, upd_i, gnt_dm_o.
module mem_arb_arb2 #(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_im_i,
    input  logic req_dm_i,
    input  logic upd_i,
    output logic gnt_dm_o
);

    // Port that wins the next tie; reset favours im.
    logic prio_dm_q;
    logic prio_dm_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_dm_q <= 1'b0;
        end else begin
            prio_dm_q <= prio_dm_d;
        end
    end

    always_comb begin
        if (DATA_PRIO) begin
            gnt_dm_o = req_dm_i;
        end else begin
            gnt_dm_o = req_dm_i & (~req_im_i | prio_dm_q);
        end
    end

    // Last-granted port loses the next tie.
    always_comb begin
        prio_dm_d = prio_dm_q;
        if (upd_i && (req_im_i || req_dm_i)) begin
            prio_dm_d = ~gnt_dm_o;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates im and dm requests onto one single-outstanding memory bus.
// Ports: clk, rst (async active-low), bus (mem_arb_if.slave: im_*, dm_*, mem_*).
import mem_arb_pkg::*;

module mem_arb #(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);

    ma_state_e     state_q, state_d;
    ma_gnt_e       gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wen_q, wen_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          abort_q, abort_d;

    logic          gnt_dm;
    logic          arb_upd;
    logic          g_valid;
    logic [AW-1:0] g_addr;
    logic          flush;
    logic          resp_fire;

    assign arb_upd = (state_q == MA_IDLE);

    mem_arb_arb2 #(
        .DATA_PRIO (DATA_PRIO)
    ) u_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req_im_i (bus.im_req_valid),
        .req_dm_i (bus.dm_req_valid),
        .upd_i    (arb_upd),
        .gnt_dm_o (gnt_dm)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MA_IDLE;
            gnt_q   <= MA_GNT_IM;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
        end
    end

    // A requester that withdraws or retargets while its transaction is
    // in flight no longer wants the answer.
    always_comb begin
        g_valid = (gnt_q == MA_GNT_DM) ? bus.dm_req_valid : bus.im_req_valid;
        g_addr  = (gnt_q == MA_GNT_DM) ? bus.dm_req_addr : bus.im_req_addr;
        flush   = ~g_valid || (g_addr != addr_q);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        unique case (state_q)
            MA_IDLE: begin
                if (bus.im_req_valid || bus.dm_req_valid) begin
                    state_d = MA_REQ;
                    if (gnt_dm) begin
                        gnt_d   = MA_GNT_DM;
                        addr_d  = bus.dm_req_addr;
                        wdata_d = bus.dm_req_wdata;
                        wen_d   = bus.dm_req_wen;
                    end else begin
                        gnt_d   = MA_GNT_IM;
                        addr_d  = bus.im_req_addr;
                        wdata_d = '0;
                        wen_d   = 1'b0;
                    end
                end
            end
            MA_REQ: begin
                if (flush) abort_d = 1'b1;
                if (bus.mem_req_ready) state_d = MA_WAIT;
            end
            MA_WAIT: begin
                if (flush) abort_d = 1'b1;
                if (bus.mem_resp_valid) begin
                    rdata_d = bus.mem_resp_rdata;
                    state_d = MA_RESP;
                end
            end
            MA_RESP: begin
                state_d = MA_IDLE;
                abort_d = 1'b0;
            end
            default: begin
                state_d = MA_IDLE;
            end
        endcase
    end

    always_comb begin
        resp_fire         = (state_q == MA_RESP) && !abort_q;
        bus.mem_req_valid = (state_q == MA_REQ);
        bus.mem_req_addr  = addr_q;
        bus.mem_req_wdata = wdata_q;
        bus.mem_req_wen   = wen_q;
        bus.im_resp_valid = resp_fire && (gnt_q == MA_GNT_IM);
        bus.dm_resp_valid = resp_fire && (gnt_q == MA_GNT_DM);
        bus.im_resp_rdata = rdata_q;
        bus.dm_resp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: fixed-priority and round-robin instances.
// Bus responders answer the cycle after acceptance with a configurable ready delay.
module tb_mem_arb;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        wen;
    } bus_t;

    typedef struct {
        bit          dm;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          wen;
        int          rdly;
        logic [63:0] exp_baddr;
        logic [63:0] exp_bwdata;
        bit          exp_bwen;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_arb_if #(.AW(64), .DW(64)) ifa ();
    mem_arb_if #(.AW(64), .DW(64)) ifb ();

    mem_arb #(.AW(64), .DW(64), .DATA_PRIO(1'b1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    mem_arb #(.AW(64), .DW(64), .DATA_PRIO(1'b0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        case (a)
            64'h1000: return 64'h13;
            64'h3000: return 64'h33;
            default:  return a ^ 64'hA5A5_0000_0000_5A5A;
        endcase
    endfunction

    // Bus responder for instance A.
    int          rdly_a = 0;
    int          wcnt_a = 0;
    bit          pend_a = 0;
    bit          stray_a = 0;
    logic [63:0] acc_addr_a = '0;
    bus_t        log_a[$];

    always @(negedge clk) begin
        ifa.mem_resp_valid = 1'b0;
        if (pend_a || stray_a) begin
            ifa.mem_resp_valid = 1'b1;
            ifa.mem_resp_rdata = pend_a ? mem_rd(acc_addr_a) : 64'hBAD_BAD;
            pend_a = 0;
            stray_a = 0;
        end
        if (ifa.mem_req_valid === 1'b1) begin
            if (wcnt_a >= rdly_a) begin
                ifa.mem_req_ready = 1'b1;
                pend_a = 1;
                acc_addr_a = ifa.mem_req_addr;
                log_a.push_back({ifa.mem_req_addr, ifa.mem_req_wdata,
                                 ifa.mem_req_wen});
                wcnt_a = 0;
            end else begin
                ifa.mem_req_ready = 1'b0;
                wcnt_a++;
            end
        end else begin
            ifa.mem_req_ready = 1'b0;
            wcnt_a = 0;
        end
    end

    // Bus responder for instance B: always ready.
    bit          pend_b = 0;
    logic [63:0] acc_addr_b = '0;
    bus_t        log_b[$];

    always @(negedge clk) begin
        ifb.mem_resp_valid = 1'b0;
        if (pend_b) begin
            ifb.mem_resp_valid = 1'b1;
            ifb.mem_resp_rdata = mem_rd(acc_addr_b);
            pend_b = 0;
        end
        if (ifb.mem_req_valid === 1'b1) begin
            ifb.mem_req_ready = 1'b1;
            pend_b = 1;
            acc_addr_b = ifb.mem_req_addr;
            log_b.push_back({ifb.mem_req_addr, ifb.mem_req_wdata,
                             ifb.mem_req_wen});
        end else begin
            ifb.mem_req_ready = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with A idle; returns at the negedge of the response.
    task automatic txn_a(input bit dm, input logic [63:0] addr,
                         input logic [63:0] wdata, input bit wen,
                         output logic [63:0] rd, output int lat,
                         output int other);
        ifa.dm_req_wdata = wdata;
        ifa.dm_req_wen = wen;
        if (dm) begin
            ifa.dm_req_addr = addr;
            ifa.dm_req_valid = 1'b1;
        end else begin
            ifa.im_req_addr = addr;
            ifa.im_req_valid = 1'b1;
        end
        lat = -1;
        other = 0;
        rd = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((dm ? ifa.im_resp_valid : ifa.dm_resp_valid) === 1'b1)
                other++;
            if ((dm ? ifa.dm_resp_valid : ifa.im_resp_valid) === 1'b1) begin
                rd = dm ? ifa.dm_resp_rdata : ifa.im_resp_rdata;
                lat = i;
                break;
            end
        end
        ifa.dm_req_valid = 1'b0;
        ifa.im_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t        vecs[6];
    logic [63:0] rd;
    int          lat, other;

    initial begin
        vecs[0] = '{dm:1'b0, addr:64'h1000, wdata:64'h0, wen:1'b0,
                    rdly:0, exp_baddr:64'h1000, exp_bwdata:64'h0,
                    exp_bwen:1'b0, exp_rdata:64'h13, exp_lat:3};
        vecs[1] = '{dm:1'b1, addr:64'h2008, wdata:64'h55, wen:1'b0,
                    rdly:0, exp_baddr:64'h2008, exp_bwdata:64'h55,
                    exp_bwen:1'b0, exp_rdata:64'hA5A5_0000_0000_7A52,
                    exp_lat:3};
        vecs[2] = '{dm:1'b1, addr:64'h2000, wdata:64'hDEAD, wen:1'b1,
                    rdly:2, exp_baddr:64'h2000, exp_bwdata:64'hDEAD,
                    exp_bwen:1'b1, exp_rdata:64'hA5A5_0000_0000_7A5A,
                    exp_lat:5};
        vecs[3] = '{dm:1'b0, addr:64'hFFFF_FFFF_FFFF_FFF8,
                    wdata:64'hFFFF_FFFF_FFFF_FFFF, wen:1'b1, rdly:1,
                    exp_baddr:64'hFFFF_FFFF_FFFF_FFF8, exp_bwdata:64'h0,
                    exp_bwen:1'b0, exp_rdata:64'h5A5A_FFFF_FFFF_A5A2,
                    exp_lat:4};
        vecs[4] = '{dm:1'b1, addr:64'h0, wdata:64'hFFFF_FFFF_FFFF_FFFF,
                    wen:1'b1, rdly:0, exp_baddr:64'h0,
                    exp_bwdata:64'hFFFF_FFFF_FFFF_FFFF, exp_bwen:1'b1,
                    exp_rdata:64'hA5A5_0000_0000_5A5A, exp_lat:3};
        vecs[5] = '{dm:1'b0, addr:64'h3000, wdata:64'h77, wen:1'b1,
                    rdly:3, exp_baddr:64'h3000, exp_bwdata:64'h0,
                    exp_bwen:1'b0, exp_rdata:64'h33, exp_lat:6};

        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.im_req_addr = '0;
        ifa.im_req_valid = 1'b0;
        ifa.dm_req_addr = '0;
        ifa.dm_req_wdata = 64'hBAD0;
        ifa.dm_req_wen = 1'b0;
        ifa.dm_req_valid = 1'b0;
        ifa.mem_req_ready = 1'b0;
        ifa.mem_resp_rdata = '0;
        ifa.mem_resp_valid = 1'b0;
        ifb.im_req_addr = '0;
        ifb.im_req_valid = 1'b0;
        ifb.dm_req_addr = '0;
        ifb.dm_req_wdata = '0;
        ifb.dm_req_wen = 1'b0;
        ifb.dm_req_valid = 1'b0;
        ifb.mem_req_ready = 1'b0;
        ifb.mem_resp_rdata = '0;
        ifb.mem_resp_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst mem_req_valid", 64'(ifa.mem_req_valid), 64'h0);
        chk("rst mem_req_addr", ifa.mem_req_addr, 64'h0);
        chk("rst mem_req_wdata", ifa.mem_req_wdata, 64'h0);
        chk("rst mem_req_wen", 64'(ifa.mem_req_wen), 64'h0);
        chk("rst im_resp_valid", 64'(ifa.im_resp_valid), 64'h0);
        chk("rst dm_resp_valid", 64'(ifa.dm_resp_valid), 64'h0);
        chk("rst im_resp_rdata", ifa.im_resp_rdata, 64'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);

        // Single transactions from the vector table.
        for (int v = 0; v < 6; v++) begin
            rdly_a = vecs[v].rdly;
            log_a.delete();
            txn_a(vecs[v].dm, vecs[v].addr, vecs[v].wdata, vecs[v].wen,
                  rd, lat, other);
            chk($sformatf("v%0d latency", v), 64'(lat),
                64'(vecs[v].exp_lat));
            chk($sformatf("v%0d rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("v%0d other resp", v), 64'(other), 64'h0);
            chk($sformatf("v%0d bus count", v), 64'(log_a.size()), 64'h1);
            if (log_a.size() > 0) begin
                chk($sformatf("v%0d bus addr", v), log_a[0].addr,
                    vecs[v].exp_baddr);
                chk($sformatf("v%0d bus wdata", v), log_a[0].wdata,
                    vecs[v].exp_bwdata);
                chk($sformatf("v%0d bus wen", v), 64'(log_a[0].wen),
                    64'(vecs[v].exp_bwen));
            end
            @(negedge clk);
        end

        // Simultaneous im+dm under fixed priority: dm first.
        begin
            int dm_lat = -1;
            int im_lat = -1;
            logic [63:0] im_rd = '0;
            rdly_a = 0;
            log_a.delete();
            ifa.im_req_addr = 64'h1000;
            ifa.dm_req_addr = 64'h2000;
            ifa.dm_req_wdata = 64'hDEAD;
            ifa.dm_req_wen = 1'b1;
            ifa.im_req_valid = 1'b1;
            ifa.dm_req_valid = 1'b1;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                if (ifa.dm_resp_valid === 1'b1 && dm_lat < 0) begin
                    dm_lat = i;
                    ifa.dm_req_valid = 1'b0;
                end
                if (ifa.im_resp_valid === 1'b1 && im_lat < 0) begin
                    im_lat = i;
                    im_rd = ifa.im_resp_rdata;
                    ifa.im_req_valid = 1'b0;
                end
                if (dm_lat > 0 && im_lat > 0) break;
            end
            ifa.im_req_valid = 1'b0;
            ifa.dm_req_valid = 1'b0;
            chk("both dm latency", 64'(dm_lat), 64'd3);
            chk("both im latency", 64'(im_lat), 64'd7);
            chk("both im rdata", im_rd, 64'h13);
            chk("both bus count", 64'(log_a.size()), 64'd2);
            if (log_a.size() >= 2) begin
                chk("both bus0", 64'(log_a[0]),
                    64'({64'h2000, 64'hDEAD, 1'b1}));
                chk("both bus1", 64'(log_a[1]),
                    64'({64'h1000, 64'h0, 1'b0}));
                chk("both bus0 wen", 64'(log_a[0].wen), 64'h1);
                chk("both bus1 addr", log_a[1].addr, 64'h1000);
            end
            repeat (2) @(negedge clk);
        end

        // Ready held low: payload must stay put until accepted.
        begin
            int vc = 0;
            int unstable = 0;
            int l5 = -1;
            rdly_a = 5;
            ifa.dm_req_addr = 64'h4000;
            ifa.dm_req_wdata = 64'h1234;
            ifa.dm_req_wen = 1'b1;
            ifa.dm_req_valid = 1'b1;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                if (ifa.mem_req_valid === 1'b1) begin
                    vc++;
                    if (ifa.mem_req_addr !== 64'h4000 ||
                        ifa.mem_req_wdata !== 64'h1234 ||
                        ifa.mem_req_wen !== 1'b1)
                        unstable++;
                end
                if (ifa.dm_resp_valid === 1'b1) begin
                    l5 = i;
                    break;
                end
            end
            ifa.dm_req_valid = 1'b0;
            rdly_a = 0;
            chk("stall valid cycles", 64'(vc), 64'd6);
            chk("stall unstable", 64'(unstable), 64'd0);
            chk("stall latency", 64'(l5), 64'd8);
            repeat (2) @(negedge clk);
        end

        // im drops in WAIT, returns at a new address.
        begin
            int first = -1;
            int dm_p = 0;
            logic [63:0] r6 = '0;
            log_a.delete();
            ifa.im_req_addr = 64'h1000;
            ifa.im_req_valid = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (ifa.dm_resp_valid === 1'b1) dm_p++;
                if (ifa.im_resp_valid === 1'b1 && first < 0) begin
                    first = i;
                    r6 = ifa.im_resp_rdata;
                    ifa.im_req_valid = 1'b0;
                    break;
                end
                if (i == 2) ifa.im_req_valid = 1'b0;
                if (i == 3) begin
                    ifa.im_req_addr = 64'h3000;
                    ifa.im_req_valid = 1'b1;
                end
            end
            ifa.im_req_valid = 1'b0;
            chk("flush first im resp", 64'(first), 64'd7);
            chk("flush rdata", r6, 64'h33);
            chk("flush dm resp", 64'(dm_p), 64'd0);
            chk("flush bus count", 64'(log_a.size()), 64'd2);
            if (log_a.size() >= 2) begin
                chk("flush bus0 addr", log_a[0].addr, 64'h1000);
                chk("flush bus1 addr", log_a[1].addr, 64'h3000);
            end
            repeat (2) @(negedge clk);
        end

        // dm retargets in REQ: stale answer dropped, new address served.
        begin
            int first = -1;
            logic [63:0] r7 = '0;
            log_a.delete();
            ifa.dm_req_addr = 64'h5000;
            ifa.dm_req_wen = 1'b0;
            ifa.dm_req_valid = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (ifa.dm_resp_valid === 1'b1) begin
                    first = i;
                    r7 = ifa.dm_resp_rdata;
                    break;
                end
                if (i == 1) ifa.dm_req_addr = 64'h5008;
            end
            ifa.dm_req_valid = 1'b0;
            chk("retarget first dm resp", 64'(first), 64'd7);
            chk("retarget rdata", r7, 64'hA5A5_0000_0000_0A52);
            chk("retarget bus count", 64'(log_a.size()), 64'd2);
            if (log_a.size() >= 2) begin
                chk("retarget bus0 addr", log_a[0].addr, 64'h5000);
                chk("retarget bus1 addr", log_a[1].addr, 64'h5008);
            end
            repeat (2) @(negedge clk);
        end

        // Async reset in the middle of REQ, then a stray bus response.
        begin
            int hits = 0;
            rdly_a = 5;
            ifa.im_req_addr = 64'h1000;
            ifa.im_req_valid = 1'b1;
            repeat (2) @(negedge clk);
            rst_a = 1'b0;
            #1;
            chk("midrst mem_req_valid", 64'(ifa.mem_req_valid), 64'h0);
            chk("midrst im_resp_valid", 64'(ifa.im_resp_valid), 64'h0);
            chk("midrst dm_resp_valid", 64'(ifa.dm_resp_valid), 64'h0);
            chk("midrst mem_req_addr", ifa.mem_req_addr, 64'h0);
            ifa.im_req_valid = 1'b0;
            @(negedge clk);
            rst_a = 1'b1;
            stray_a = 1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (ifa.im_resp_valid === 1'b1 || ifa.dm_resp_valid === 1'b1 ||
                    ifa.mem_req_valid === 1'b1)
                    hits++;
            end
            chk("postrst activity", 64'(hits), 64'd0);
            rdly_a = 0;
            txn_a(1'b0, 64'h1000, 64'h0, 1'b0, rd, lat, other);
            chk("postrst latency", 64'(lat), 64'd3);
            chk("postrst rdata", rd, 64'h13);
            @(negedge clk);
        end

        // Round-robin: both held valid, grants alternate starting with im.
        begin
            bit pq[$];
            log_b.delete();
            ifb.im_req_addr = 64'h100;
            ifb.dm_req_addr = 64'h200;
            ifb.dm_req_wen = 1'b0;
            ifb.im_req_valid = 1'b1;
            ifb.dm_req_valid = 1'b1;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                if (ifb.im_resp_valid === 1'b1) pq.push_back(1'b0);
                if (ifb.dm_resp_valid === 1'b1) pq.push_back(1'b1);
            end
            ifb.im_req_valid = 1'b0;
            ifb.dm_req_valid = 1'b0;
            repeat (6) @(negedge clk);
            chk("rr bus count", 64'(log_b.size()), 64'd4);
            chk("rr resp count", 64'(pq.size()), 64'd4);
            if (log_b.size() >= 4) begin
                chk("rr bus0", log_b[0].addr, 64'h100);
                chk("rr bus1", log_b[1].addr, 64'h200);
                chk("rr bus2", log_b[2].addr, 64'h100);
                chk("rr bus3", log_b[3].addr, 64'h200);
            end
            if (pq.size() >= 4) begin
                chk("rr resp order",
                    64'({pq[0], pq[1], pq[2], pq[3]}), 64'b0101);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
